escalonador_tx: RTL
===================

# escalonador_tx

Round-robin frame scheduler that shares one serial transmit line among N_REQ requesters. Each requester presents a 4-bit `dado` and a 4-bit `instrucao`. The block arbitrates between pending requests, latches the winner's operands and acknowledges it with a one-cycle grant. It then serialises a 10-bit frame on `out`: start bit 0, `dado[0..3]`, `instrucao[0..3]`, stop bit 1. The block sits between the command sources (panel logic, sequencers) and the serial link to the receiving board.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, default 1: clock cycles each frame bit is held, minimum 1.

Ports (clock and reset first):
- `clock` in, 1: single system clock; all state updates on the rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `req` in, N_REQ: level request per requester; held high until granted.
- `dado_in` in, 4*N_REQ: requester i's data on bits [4i+3:4i].
- `instrucao_in` in, 4*N_REQ: requester i's instruction on bits [4i+3:4i].
- `grant` out, N_REQ: one-hot acknowledge, high for exactly one cycle when requester i's operands are latched.
- `origem` out, clog2(N_REQ): index of the requester whose frame is in flight or was sent last.
- `busy` out, 1: high while a frame occupies the line (start bit through end of stop bit).
- `out` out, 1: serial line; idle level 1.

## Operation

- States:
  - IDLE: line at 1, no frame.
  - START: bit 0.
  - DATA: bits 1–4 are `dado[0..3]`.
  - INSTR: bits 5–8 are `instrucao[0..3]`.
  - STOP: bit 9 = 1.
- Transitions:
  - IDLE→START on any `req` high.
  - START→DATA after one bit time.
  - DATA→INSTR after 4 bit times.
  - INSTR→STOP after 4 bit times.
  - STOP→IDLE after one bit time.
- Arbitration:
  - Rotating pointer `ptr`, reset value 0.
  - Winner is the first requester with `req` high when searching `ptr`, `ptr+1`, …, wrapping modulo N_REQ.
  - After the grant, `ptr` becomes winner+1 modulo N_REQ.
- Latching:
  - On the arbitration edge the block registers the winner's `dado`/`instrucao` slice into internal A/B, sets `origem`, pulses `grant`, and drives `out`=0.
  - `req`, `dado_in` and `instrucao_in` are ignored for the rest of the frame.
- Bit counter 0..9 and bit-time counter 0..CLKS_PER_BIT-1; both wrap to 0 on frame end.
- A requester that keeps `req` high after its grant is treated as a new request and is served again when rotation reaches it.
- Reset (asserted at any time, including mid-frame):
  - `out`=1, `busy`=0, `grant`=0, `origem`=0, `ptr`=0, state IDLE, counters 0.
  - A partial frame is abandoned; it is not resumed.

## Timing

- Arbitration edge E, with `req` sampled while in IDLE:
  - From E+0 (output registered after E): `grant` high for 1 cycle, `busy`=1, `out`=0.
- Bit k (k=0..9) is driven for cycles [E + k·CLKS_PER_BIT, E + (k+1)·CLKS_PER_BIT).
- `busy` falls at E + 10·CLKS_PER_BIT, on entry to IDLE. The earliest next arbitration edge is that same cycle's edge.
- Back-to-back frame period = 10·CLKS_PER_BIT + 1 cycles, so `out` stays at 1 for at least one cycle between frames.
- Arbitration latency with the line idle: 1 edge from `req` rising.
- Simultaneous requests resolve by the pointer; no requester waits more than N_REQ−1 frames.
- `req` dropping before its grant withdraws the request with no side effects.
- `grant` never asserts while `busy` is already high from a previous frame.

## Test plan

1. Single request (CLKS_PER_BIT=1): `req`=0001, `dado`0=4'hA, `instrucao`0=4'h3 → `grant`=0001 for 1 cycle, `origem`=0, `out` sequence 0,0,1,0,1,1,1,0,0,1, `busy` high for 10 cycles.
2. All four request continuously: `req`=1111 held → grants 0001, 0010, 0100, 1000, 0001, each 11 cycles apart; each frame carries its own requester's operands.
3. Pointer rotation: serve requester 1 alone, then `req`=0011 → requester 0 wins (search 2,3,0,1); `origem`=0.
4. CLKS_PER_BIT=3, `dado`=4'h5, `instrucao`=4'hC → each bit held exactly 3 cycles, `busy` high 30 cycles, bit pattern 0,1,0,1,0,0,0,1,1,1.
5. Reset mid-frame: drop `reset_n` during bit 5 → `out`=1 and `busy`=0 immediately (asynchronous). After release with `req`=0010 → `grant`=0010 and a full fresh frame.
6. Operand change mid-frame: change `dado_in`/`instrucao_in` of the active requester after its grant → transmitted bits match the values latched at grant.

Source files
------------

// File: rtl/escalonador_tx.sv
// Round-robin scheduler: grants one of N_REQ requesters and serialises its
// 10-bit frame (start 0, dado[0..3], instrucao[0..3], stop 1) on one line.
module escalonador_tx #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 1,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] dado_in,
  input  logic [4*N_REQ-1:0] instrucao_in,
  output logic [N_REQ-1:0]   grant,
  output logic [IW-1:0]      origem,
  output logic               busy,
  output logic               out
);

  typedef enum logic [2:0] {IDLE, START, DATA, INSTR, STOP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [3:0]       bit_q, bit_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    origem_q, origem_d;
  logic             busy_q, busy_d;
  logic             out_q, out_d;

  logic [IW-1:0]    win;
  logic             found;
  logic [IW:0]      idx_sum;
  logic [IW:0]      ptr_sum;
  logic [IW-1:0]    ptr_nxt;
  logic [3:0]       sel_a, sel_b;
  logic [3:0]       nxt_bit;

  function automatic logic frame_bit(input logic [3:0] n, input logic [3:0] a,
                                     input logic [3:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, a, 1'b0};
    return (n <= 4'd9) ? fr[n] : 1'b1;
  endfunction

  // Search from ptr upwards; iterating the offsets downwards lets the
  // smallest offset with a pending request overwrite the others.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    idx_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx_sum >= (IW+1)'(N_REQ)) idx_sum = idx_sum - (IW+1)'(N_REQ);
      if (req[idx_sum[IW-1:0]]) begin
        win   = idx_sum[IW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_sum = {1'b0, win} + (IW+1)'(1);
    if (ptr_sum >= (IW+1)'(N_REQ)) ptr_sum = '0;
    ptr_nxt = ptr_sum[IW-1:0];
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) begin
        sel_a = dado_in[4*i +: 4];
        sel_b = instrucao_in[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    bit_d    = bit_q;
    tick_d   = tick_q;
    a_d      = a_q;
    b_d      = b_q;
    grant_d  = '0;
    origem_d = origem_q;
    busy_d   = busy_q;
    out_d    = out_q;
    nxt_bit  = bit_q + 4'd1;
    case (state_q)
      IDLE: begin
        out_d  = 1'b1;
        busy_d = 1'b0;
        if (found) begin
          state_d  = START;
          a_d      = sel_a;
          b_d      = sel_b;
          origem_d = win;
          grant_d  = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          ptr_d    = ptr_nxt;
          bit_d    = '0;
          tick_d   = '0;
          busy_d   = 1'b1;
          out_d    = 1'b0;
        end
      end
      default: begin
        if (tick_q == TW'(CLKS_PER_BIT - 1)) begin
          tick_d = '0;
          if (bit_q == 4'd9) begin
            // Stop bit done: line returns to idle for at least one cycle.
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            out_d   = 1'b1;
          end else begin
            bit_d = nxt_bit;
            out_d = frame_bit(nxt_bit, a_q, b_q);
            if (nxt_bit <= 4'd4)      state_d = DATA;
            else if (nxt_bit <= 4'd8) state_d = INSTR;
            else                      state_d = STOP;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      bit_q    <= '0;
      tick_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      grant_q  <= '0;
      origem_q <= '0;
      busy_q   <= 1'b0;
      out_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      bit_q    <= bit_d;
      tick_q   <= tick_d;
      a_q      <= a_d;
      b_q      <= b_d;
      grant_q  <= grant_d;
      origem_q <= origem_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
    end
  end

  assign grant  = grant_q;
  assign origem = origem_q;
  assign busy   = busy_q;
  assign out    = out_q;

endmodule
